// File: rtl/multicycle_ctrl.sv
// Multicycle RV32-style instruction sequencer: FETCH/DECODE/EXEC/MEM/WB/TRAP control FSM.
// Define PERF_CNT_EN to add the 32-bit instret retire counter output.
module multicycle_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [6:0]  opcode,
   input  logic        imem_ack,
   input  logic        dmem_ack,
   input  logic        branch_taken,
   output logic        imem_req,
   output logic        ir_we,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic        pc_we,
   output logic [1:0]  pc_sel,
   output logic [1:0]  alu_op,
   output logic        alu_src,
   output logic        reg_write,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic [2:0]  state
`ifdef PERF_CNT_EN
   ,
   output logic [31:0] instret
`endif
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] PC_PLUS4 = 2'b00;
   localparam logic [1:0] PC_IMM   = 2'b01;
   localparam logic [1:0] PC_REG   = 2'b10;

   localparam logic [1:0] ALU_ADD  = 2'b00;
   localparam logic [1:0] ALU_CMP  = 2'b01;
   localparam logic [1:0] ALU_FUNC = 2'b10;

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;

   logic is_r, is_i, is_load, is_store, is_branch;
   logic is_lui, is_auipc, is_jal, is_jalr, is_legal;

   logic       imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, pc_we_c;
   logic [1:0] pc_sel_c, alu_op_c;
   logic       alu_src_c, reg_write_c, mem_to_reg_c;

   assign is_r      = (opcode == OP_R);
   assign is_i      = (opcode == OP_I);
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign is_branch = (opcode == OP_BRANCH);
   assign is_lui    = (opcode == OP_LUI);
   assign is_auipc  = (opcode == OP_AUIPC);
   assign is_jal    = (opcode == OP_JAL);
   assign is_jalr   = (opcode == OP_JALR);
   assign is_legal  = is_r | is_i | is_load | is_store | is_branch |
                      is_lui | is_auipc | is_jal | is_jalr;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      illegal_d    = illegal_q;
      imem_req_c   = 1'b0;
      ir_we_c      = 1'b0;
      dmem_req_c   = 1'b0;
      dmem_we_c    = 1'b0;
      pc_we_c      = 1'b0;
      pc_sel_c     = PC_PLUS4;
      alu_op_c     = ALU_ADD;
      alu_src_c    = 1'b0;
      reg_write_c  = 1'b0;
      mem_to_reg_c = 1'b0;

      case (state_q)
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (imem_ack) begin
               ir_we_c = 1'b1;
               state_d = S_DECODE;
            end
         end

         S_DECODE: begin
            if (is_legal) begin
               state_d = S_EXEC;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end

         S_EXEC: begin
            if (is_r) begin
               alu_op_c  = ALU_FUNC;
               alu_src_c = 1'b0;
            end else if (is_i) begin
               alu_op_c  = ALU_FUNC;
               alu_src_c = 1'b1;
            end else if (is_branch) begin
               alu_op_c  = ALU_CMP;
               alu_src_c = 1'b0;
            end else begin
               alu_op_c  = ALU_ADD;
               alu_src_c = 1'b1;
            end

            // Branches retire here; memory ops go on to MEM, everything else to WB.
            if (is_branch) begin
               pc_we_c  = 1'b1;
               pc_sel_c = branch_taken ? PC_IMM : PC_PLUS4;
               state_d  = S_FETCH;
            end else if (is_load || is_store) begin
               state_d = S_MEM;
            end else begin
               state_d = S_WB;
            end
         end

         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = is_store;
            if (dmem_ack) begin
               if (is_store) begin
                  pc_we_c  = 1'b1;
                  pc_sel_c = PC_PLUS4;
                  state_d  = S_FETCH;
               end else begin
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            reg_write_c  = 1'b1;
            pc_we_c      = 1'b1;
            mem_to_reg_c = is_load;
            if (is_jal) begin
               pc_sel_c = PC_IMM;
            end else if (is_jalr) begin
               pc_sel_c = PC_REG;
            end else begin
               pc_sel_c = PC_PLUS4;
            end
            state_d = S_FETCH;
         end

         S_TRAP: begin
            state_d = S_TRAP;
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Reset gates every output combinationally so nothing leaks while rst_n is low.
   assign imem_req   = rst_n & imem_req_c;
   assign ir_we      = rst_n & ir_we_c;
   assign dmem_req   = rst_n & dmem_req_c;
   assign dmem_we    = rst_n & dmem_we_c;
   assign pc_we      = rst_n & pc_we_c;
   assign pc_sel     = rst_n ? pc_sel_c : 2'b00;
   assign alu_op     = rst_n ? alu_op_c : 2'b00;
   assign alu_src    = rst_n & alu_src_c;
   assign reg_write  = rst_n & reg_write_c;
   assign mem_to_reg = rst_n & mem_to_reg_c;
   assign illegal    = rst_n & illegal_q;
   assign state      = rst_n ? state_q : 3'b000;

`ifdef PERF_CNT_EN
   logic [31:0] instret_q, instret_d;

   always_comb begin
      instret_d = instret_q;
      if (pc_we_c && (state_q != S_TRAP)) begin
         instret_d = instret_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         instret_q <= 32'd0;
      end else begin
         instret_q <= instret_d;
      end
   end

   assign instret = rst_n ? instret_q : 32'd0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; every cycle compares the packed output vector.
module tb_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [6:0]  opcode;
   logic        imem_ack, dmem_ack, branch_taken;
   logic        imem_req, ir_we, dmem_req, dmem_we, pc_we;
   logic [1:0]  pc_sel, alu_op;
   logic        alu_src, reg_write, mem_to_reg, illegal;
   logic [2:0]  state;
`ifdef PERF_CNT_EN
   logic [31:0] instret;
`endif

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BAD    = 7'b1111111;

   multicycle_ctrl dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .opcode       (opcode),
      .imem_ack     (imem_ack),
      .dmem_ack     (dmem_ack),
      .branch_taken (branch_taken),
      .imem_req     (imem_req),
      .ir_we        (ir_we),
      .dmem_req     (dmem_req),
      .dmem_we      (dmem_we),
      .pc_we        (pc_we),
      .pc_sel       (pc_sel),
      .alu_op       (alu_op),
      .alu_src      (alu_src),
      .reg_write    (reg_write),
      .mem_to_reg   (mem_to_reg),
      .illegal      (illegal),
      .state        (state)
`ifdef PERF_CNT_EN
      ,
      .instret      (instret)
`endif
   );

   always #5 clk = ~clk;

   logic [15:0] obs;
   assign obs = {imem_req, ir_we, dmem_req, dmem_we, pc_we, pc_sel, alu_op,
                 alu_src, reg_write, mem_to_reg, illegal, state};

   function automatic logic [15:0] ev(input logic [2:0] st, input logic ireq, input logic irwe,
                                      input logic dreq, input logic dwe, input logic pcwe,
                                      input logic [1:0] pcsel, input logic [1:0] aluop,
                                      input logic asrc, input logic rw, input logic m2r,
                                      input logic ill);
      return {ireq, irwe, dreq, dwe, pcwe, pcsel, aluop, asrc, rw, m2r, ill, st};
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Check outputs mid-cycle, then advance to just after the next rising edge.
   task automatic cyc(input string tag, input logic [15:0] exp);
      @(negedge clk);
      check(tag, {16'd0, obs}, {16'd0, exp});
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; opcode = OP_R; imem_ack = 1'b1; dmem_ack = 1'b1; branch_taken = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cyc("rst_low", 16'd0);
      rst_n = 1'b0;
      rst_n = 1'b1;
      imem_ack = 1'b0;

      cyc("rel_fetch",  ev(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("fetch_wait", ev(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));

      imem_ack = 1'b1; dmem_ack = 1'b1; opcode = OP_R;
      cyc("r_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("r_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("r_e", ev(2,0,0,0,0,0,2'b00,2'b10,0,0,0,0));
      cyc("r_w", ev(4,0,0,0,0,1,2'b00,2'b00,0,1,0,0));

      opcode = OP_I;
      cyc("i_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("i_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("i_e", ev(2,0,0,0,0,0,2'b00,2'b10,1,0,0,0));
      cyc("i_w", ev(4,0,0,0,0,1,2'b00,2'b00,0,1,0,0));

      opcode = OP_LOAD; dmem_ack = 1'b0;
      cyc("ld_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("ld_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("ld_e", ev(2,0,0,0,0,0,2'b00,2'b00,1,0,0,0));
      for (int k = 0; k < 3; k++) cyc("ld_mwait", ev(3,0,0,1,0,0,2'b00,2'b00,0,0,0,0));
      dmem_ack = 1'b1;
      cyc("ld_mack", ev(3,0,0,1,0,0,2'b00,2'b00,0,0,0,0));
      dmem_ack = 1'b0;
      cyc("ld_w",    ev(4,0,0,0,0,1,2'b00,2'b00,0,1,1,0));

      opcode = OP_STORE; dmem_ack = 1'b1;
      cyc("st_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("st_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("st_e", ev(2,0,0,0,0,0,2'b00,2'b00,1,0,0,0));
      cyc("st_m", ev(3,0,0,1,1,1,2'b00,2'b00,0,0,0,0));

      opcode = OP_BRANCH; branch_taken = 1'b1;
      cyc("bt_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("bt_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("bt_e", ev(2,0,0,0,0,1,2'b01,2'b01,0,0,0,0));
      branch_taken = 1'b0;
      cyc("bn_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("bn_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("bn_e", ev(2,0,0,0,0,1,2'b00,2'b01,0,0,0,0));

      opcode = OP_JAL;
      cyc("jal_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("jal_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("jal_e", ev(2,0,0,0,0,0,2'b00,2'b00,1,0,0,0));
      cyc("jal_w", ev(4,0,0,0,0,1,2'b01,2'b00,0,1,0,0));

      opcode = OP_JALR;
      cyc("jalr_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("jalr_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("jalr_e", ev(2,0,0,0,0,0,2'b00,2'b00,1,0,0,0));
      cyc("jalr_w", ev(4,0,0,0,0,1,2'b10,2'b00,0,1,0,0));

      opcode = OP_LUI;
      cyc("lui_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("lui_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("lui_e", ev(2,0,0,0,0,0,2'b00,2'b00,1,0,0,0));
      cyc("lui_w", ev(4,0,0,0,0,1,2'b00,2'b00,0,1,0,0));

      // Store interrupted by reset while its data request is outstanding.
      opcode = OP_STORE; dmem_ack = 1'b0;
      cyc("sr_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("sr_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("sr_e", ev(2,0,0,0,0,0,2'b00,2'b00,1,0,0,0));
      cyc("sr_m", ev(3,0,0,1,1,0,2'b00,2'b00,0,0,0,0));
      rst_n = 1'b0;
      cyc("sr_rst", 16'd0);
      rst_n = 1'b1; imem_ack = 1'b0; dmem_ack = 1'b1;
      cyc("sr_fetch",  ev(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("sr_spur",   ev(0,1,0,0,0,0,2'b00,2'b00,0,0,0,0));

      opcode = OP_BAD; imem_ack = 1'b1;
      cyc("il_f", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));
      cyc("il_d", ev(1,0,0,0,0,0,2'b00,2'b00,0,0,0,0));
      for (int k = 0; k < 20; k++) cyc("il_trap", ev(5,0,0,0,0,0,2'b00,2'b00,0,0,0,1));
      rst_n = 1'b0;
      cyc("il_rst", 16'd0);
      rst_n = 1'b1;
      cyc("il_fetch", ev(0,1,1,0,0,0,2'b00,2'b00,0,0,0,0));

`ifdef PERF_CNT_EN
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1; opcode = OP_R; imem_ack = 1'b1; dmem_ack = 1'b1;
      repeat (20) tick();
      @(negedge clk);
      check("instret_5", instret, 32'd5);
      tick();
      imem_ack = 1'b0;
      force dut.instret_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.instret_q;
      tick();
      opcode = OP_BRANCH; branch_taken = 1'b1; imem_ack = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("instret_wrap", instret, 32'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
